mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. Converts CPU load/store requests (byte, halfword, word; signed or unsigned loads) into word-aligned MemRead/MemWrite cycles on the 1 KB byte-addressed, little-endian data memory.
- Sub-word stores use read-modify-write.
- Sits between the CPU datapath's MEM stage and the memory block. Holds the CPU off with a valid/ready handshake until the access completes.

Parameters:
- MEM_BYTES, 1024, size of the attached memory in bytes; accesses beyond it are errors.
- AW, 32, request and memory address width.

Ports:
- clk  in  1  rising-edge clock, shared with memory
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, illegal size, or out of range
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- addr  out  AW  memory byte address, always {req_addr[AW-1:2],2'b00}
- wd  out  32  memory write data
- rd  in  32  memory read data, combinational while MemRead=1

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset values (any edge with rst_n=0): state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, captured word=0. MemRead, MemWrite, addr and wd are all 0.
- Outputs are decoded from state:
  - req_ready = (state==IDLE).
  - MemRead = (state==RD).
  - MemWrite = (state==WR) && rst_n, so a write never commits on an edge where reset is asserted.
  - addr and wd are 0 outside RD/WR.
- Accept: handshake on the edge where req_valid && req_ready. Latch we, size, unsigned, addr and wdata.
- Error check at accept. An error makes the next state RESP with resp_err=1 and no memory cycle issued. Error conditions:
  - size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - word-aligned addr > MEM_BYTES-4
- Load: IDLE → RD (one cycle; capture rd at the edge) → RESP. Lane select uses addr[1:0]:
  - byte = word[8*a+7:8*a]
  - half = word[16*a[1]+15:16*a[1]]
  - extend per req_unsigned
  - Latency: resp_valid is high on the 2nd cycle after the accept edge.
- Store word: IDLE → WR (wd=wdata, one cycle) → RESP.
- Store byte/half: IDLE → RD (capture old word) → WR (old word with the selected lane replaced by wdata[7:0] or [15:0]) → RESP. Other lanes are unchanged.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_valid is ignored in RD, WR and RESP. A new request is accepted at earliest on the edge ending the first IDLE cycle after RESP.
- Request fields may change after acceptance without effect.
- Reset mid-operation returns to IDLE next edge; no resp_valid for the aborted request and no partial write.
- Unknown (X) rd outside RD is never sampled.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - state enum {IDLE, RD, WR, RESP}
  - MEM_BYTES default
- One natural sub-module: mem_lane_align, purely combinational, used for both loads and stores. Given size, addr[1:0] and unsigned, it extracts and extends load data and merges store data into a word.

Test Plan:
- Preload mem[0x10..0x13]=11,22,33,84; lw 0x10 → MemRead exactly 1 cycle at addr 0x10, resp_rdata=0x84332211, resp_err=0, resp_valid 2 cycles after accept.
- Same data; lb 0x13 → 0xFFFFFF84; lbu 0x13 → 0x00000084; lh 0x12 → 0xFFFF8433; lhu 0x12 → 0x00008433.
- sb 0x11 wdata 0x123456AA → one RD then one WR at addr 0x10 with wd=0x8433AA11; a following lw 0x10 returns 0x8433AA11.
- lw 0x12, lh 0x11, size=11, lw 0x400 → each gives resp_valid with resp_err=1 and rdata 0, no MemRead/MemWrite; lw 0x3FC → resp_err=0.
- sw 0x20 0xDEADBEEF with rst_n=0 during the WR cycle → no write (mem[0x20..0x23] unchanged), no resp_valid, req_ready=1 the cycle after reset releases.
- req_valid held high across back-to-back lw → second accept only after RESP and one IDLE cycle; each request gets exactly one resp_valid pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data-memory access unit
// Purpose: access-size codes, FSM state type, default memory size and the
//          size/alignment legality helper used at request accept.
// Ports:   none (package)
package mem_pkg;

    localparam int MEM_BYTES_DEF = 1024;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    // True when the size code is illegal or the byte lane is not naturally
    // aligned for that size.
    function automatic logic bad_size_or_align(input logic [1:0] size,
                                               input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane extract/extend for loads, lane merge for stores
// Purpose: combinational lane steering between a 32-bit little-endian memory
//          word and right-justified CPU data.
// Ports:   size_i      access size code
//          lane_i      byte offset within the word (addr[1:0])
//          unsigned_i  zero-extend (1) or sign-extend (0) loads
//          rword_i     word read from memory (load source)
//          old_word_i  previously captured word (read-modify-write base)
//          wdata_i     right-justified store data
//          load_data_o extended load result
//          merged_o    word to write back to memory
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rword_i[{lane_i, 3'b000} +: 8];
        half_v = rword_i[{lane_i[1], 4'b0000} +: 16];

        case (size_i)
            SZ_B:    load_data_o = unsigned_i ? {24'b0, byte_v}
                                              : {{24{byte_v[7]}}, byte_v};
            SZ_H:    load_data_o = unsigned_i ? {16'b0, half_v}
                                              : {{16{half_v[15]}}, half_v};
            default: load_data_o = rword_i;
        endcase
    end

    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SZ_B:    merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_H:    merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_W:    merged_o = wdata_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store to word-aligned data-memory cycles
// Purpose: accepts one load/store at a time, checks it, runs a read, a write,
//          or a read-modify-write on the memory and returns a one-cycle response.
// Ports:   clk, rst_n                 clock, synchronous active-low reset
//          req_valid/req_ready        request handshake (ready only in IDLE)
//          req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//          resp_valid, resp_rdata, resp_err                     response
//          MemRead, MemWrite, addr, wd, rd                      memory side
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] addr,
    output logic [31:0]   wd,
    input  logic [31:0]   rd
);

    localparam logic [AW-1:0] LAST_WORD = AW'(MEM_BYTES - 4);

    state_e        state_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   word_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic [AW-1:0] req_word_addr;
    logic          req_bad;
    logic [31:0]   load_data;
    logic [31:0]   merged_word;

    assign req_word_addr = {req_addr[AW-1:2], 2'b00};
    assign req_bad       = bad_size_or_align(req_size, req_addr[1:0])
                         || (req_word_addr > LAST_WORD);

    mem_lane_align u_align (
        .size_i      (size_q),
        .lane_i      (addr_q[1:0]),
        .unsigned_i  (uns_q),
        .rword_i     (rd),
        .old_word_i  (word_q),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_bad) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we && (req_size == SZ_W)) begin
                            // Full-word store needs no old data.
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    word_q <= rd;
                    if (we_q) begin
                        state_q <= WR;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                    end
                end
                WR: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign MemRead    = (state_q == RD);
    // Gated by reset so an aborted store never lands on the reset edge.
    assign MemWrite   = (state_q == WR) && rst_n;
    assign addr       = ((state_q == RD) || (state_q == WR))
                      ? {addr_q[AW-1:2], 2'b00} : '0;
    assign wd         = (state_q == WR) ? merged_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [31:0]   rd;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(1024), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .addr         (addr),
        .wd           (wd),
        .rd           (rd)
    );

    logic [7:0] mem      [1024];
    logic [7:0] init_img [1024];
    logic [7:0] ref_mem  [1024];
    logic       init_pending;

    int n_assert = 0;
    int n_fail   = 0;

    int          m_lat, m_nrd, m_nwr;
    logic        m_got, m_err;
    logic [31:0] m_rdata, m_waddr, m_wd;

    always_comb begin
        if (MemRead)
            rd = {mem[{addr[9:2], 2'd3}], mem[{addr[9:2], 2'd2}],
                  mem[{addr[9:2], 2'd1}], mem[{addr[9:2], 2'd0}]};
        else
            rd = 'x;
    end

    always @(posedge clk) begin
        if (init_pending) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_img[i];
        end else if (MemWrite) begin
            mem[{addr[9:2], 2'd0}] <= wd[7:0];
            mem[{addr[9:2], 2'd1}] <= wd[15:8];
            mem[{addr[9:2], 2'd2}] <= wd[23:16];
            mem[{addr[9:2], 2'd3}] <= wd[31:24];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input int base);
        longint v;
        v = 0;
        for (int i = 0; i < 4; i++) v = v + (longint'(ref_mem[base + i]) << (8 * i));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
        int     n;
        longint v;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v + (longint'(ref_mem[int'(a[9:0]) + i]) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input int n, input logic [31:0] a, input logic [31:0] wdata);
        logic [31:0] tmp;
        for (int i = 0; i < n; i++) begin
            tmp = wdata >> (8 * i);
            ref_mem[int'(a[9:0]) + i] = tmp[7:0];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wdata);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wdata;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        m_lat = 0; m_nrd = 0; m_nwr = 0; m_got = 0; m_err = 0;
        m_rdata = 0; m_waddr = 0; m_wd = 0;
        while (!m_got && m_lat < 8) begin
            @(negedge clk);
            m_lat++;
            if (MemRead) begin
                m_nrd++;
                chk("rd_addr", addr, a & ~32'd3);
            end
            if (MemWrite) begin
                m_nwr++;
                m_waddr = addr;
                m_wd    = wd;
            end
            if (resp_valid) begin
                m_got   = 1'b1;
                m_rdata = resp_rdata;
                m_err   = resp_err;
            end
        end
        chk("resp_seen", {31'b0, m_got}, 32'd1);
        @(negedge clk);
        chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wdata);
        int          n, exp_lat, exp_nrd, exp_nwr;
        logic        bad;
        logic [31:0] exp_rd, base;
        n    = nbytes(sz);
        base = a - (a % 4);
        bad  = (sz == 2'd3) || (a % n != 0) || (base > 32'd1020);
        exp_rd = 0;
        if (bad) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (!we) begin
            exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
            exp_rd  = ref_load(sz, uns, a);
        end else begin
            exp_lat = (n == 4) ? 2 : 3;
            exp_nrd = (n == 4) ? 0 : 1;
            exp_nwr = 1;
            ref_store(n, a, wdata);
        end
        do_req(we, sz, uns, a, wdata);
        chk("rdata", m_rdata, exp_rd);
        chk("err", {31'b0, m_err}, {31'b0, bad});
        chk("latency", 32'(m_lat), 32'(exp_lat));
        chk("n_memread", 32'(m_nrd), 32'(exp_nrd));
        chk("n_memwrite", 32'(m_nwr), 32'(exp_nwr));
        if (!bad && we) begin
            chk("wr_addr", m_waddr, base);
            chk("wr_data", m_wd, ref_word(int'(base)));
        end
    endtask

    initial begin
        logic [31:0] a, wdata;
        logic [1:0]  sz;
        int          r, n, acc_n, resp_n, mism, any_resp;
        int          acc_k[2], resp_k[2];
        logic [31:0] resp_d[2];
        logic [31:0] exp_w;

        rst_n = 1'b0; init_pending = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            init_img[i] = 8'($urandom);
        end
        init_img[16] = 8'h11; init_img[17] = 8'h22; init_img[18] = 8'h33; init_img[19] = 8'h84;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_img[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_pending = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_memread", {31'b0, MemRead}, 32'd0);
        chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wd", wd, 32'd0);
        rst_n = 1'b1;

        // Directed loads on the preloaded word.
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("lw10", m_rdata, 32'h84332211);
        run_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        chk("lb13", m_rdata, 32'hFFFFFF84);
        run_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        chk("lbu13", m_rdata, 32'h00000084);
        run_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        chk("lh12", m_rdata, 32'hFFFF8433);
        run_txn(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        chk("lhu12", m_rdata, 32'h00008433);

        // Byte store via read-modify-write.
        run_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA);
        chk("sb11_wd", m_wd, 32'h8433AA11);
        chk("sb11_waddr", m_waddr, 32'h10);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("lw10_after_sb", m_rdata, 32'h8433AA11);

        // Error cases and last legal word.
        run_txn(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
        chk("err_lw12", {31'b0, m_err}, 32'd1);
        run_txn(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        chk("err_lh11", {31'b0, m_err}, 32'd1);
        run_txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        chk("err_size3", {31'b0, m_err}, 32'd1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        chk("err_lw400", {31'b0, m_err}, 32'd1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        chk("ok_lw3fc", {31'b0, m_err}, 32'd0);

        // Reset asserted during the write cycle of a word store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
        any_resp = 0;
        repeat (4) begin
            if (resp_valid) any_resp++;
            @(negedge clk);
        end
        chk("abort_no_resp", 32'(any_resp), 32'd0);
        exp_w = {mem[35], mem[34], mem[33], mem[32]};
        chk("abort_mem20", exp_w, ref_word(32));

        // Back-to-back loads with req_valid held high.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        acc_n = 0; resp_n = 0;
        acc_k[0] = -1; acc_k[1] = -1; resp_k[0] = -1; resp_k[1] = -1;
        resp_d[0] = 0; resp_d[1] = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                if (acc_n < 2) acc_k[acc_n] = k;
                acc_n++;
            end
            if (resp_valid) begin
                if (resp_n < 2) begin
                    resp_k[resp_n] = k;
                    resp_d[resp_n] = resp_rdata;
                end
                resp_n++;
            end
            @(negedge clk);
        end
        exp_w = ref_load(2'd2, 1'b0, 32'h10);
        chk("b2b_acc_n", 32'(acc_n), 32'd2);
        chk("b2b_acc0", 32'(acc_k[0]), 32'd0);
        chk("b2b_acc1", 32'(acc_k[1]), 32'd3);
        chk("b2b_resp_n", 32'(resp_n), 32'd2);
        chk("b2b_resp0", 32'(resp_k[0]), 32'd2);
        chk("b2b_resp1", 32'(resp_k[1]), 32'd5);
        chk("b2b_data0", resp_d[0], exp_w);
        chk("b2b_data1", resp_d[1], exp_w);

        // Randomized traffic against the byte-array reference.
        for (int t = 0; t < 80; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            n  = nbytes(sz);
            if ($urandom_range(0, 7) == 0) a = $urandom_range(1021, 1100);
            else                           a = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) a = a - (a % n);
            wdata = $urandom;
            run_txn(1'($urandom), sz, 1'($urandom), a, wdata);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("final_mem", 32'(mism), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
